gru_top: RTL and testbench

GRU_TOP -- requirements
Module: gru_top

---
 rtl/gru_pkg.sv | 109 ++++++++++
 rtl/gru_if.sv | 20 ++
 rtl/gru_model.sv | 110 +++++++++++
 rtl/gru_top.sv | 128 ++++++++++++
 tb/tb_gru_top.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gru_pkg.sv
// -----------------------------------------------------------------------------
// gru_pkg -- shared definitions for the single-unit GRU demo.
//
// Contents:
//   q16_t            signed Q16.16 fixed-point word
//   gru_state_t      FSM encoding of gru_model (IDLE=0 .. DONE=6)
//   WZ..BO           scalar GRU weights/biases in Q16.16
//   X_SEQ            input sequence ROM (8 entries)
//   q_mul/q_add/q_sub/q_sig/q_tanh  saturating Q16.16 helpers
// -----------------------------------------------------------------------------
package gru_pkg;

  typedef logic signed [31:0] q16_t;

  localparam q16_t Q_ONE     = 32'sh0001_0000;
  localparam q16_t Q_HALF    = 32'sh0000_8000;
  localparam q16_t Q_NEG_ONE = 32'shFFFF_0000;
  localparam q16_t Q_MAX     = 32'sh7FFF_FFFF;
  localparam q16_t Q_MIN     = 32'sh8000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    GATES  = 3'd2,
    CAND   = 3'd3,
    UPDATE = 3'd4,
    OUTPUT = 3'd5,
    DONE   = 3'd6
  } gru_state_t;

  localparam q16_t WZ = 32'sh0000_0000;
  localparam q16_t UZ = 32'sh0000_0000;
  localparam q16_t BZ = 32'sh0000_0000;
  localparam q16_t WR = 32'sh0000_0000;
  localparam q16_t UR = 32'sh0000_0000;
  localparam q16_t BR = 32'sh0000_0000;
  localparam q16_t WN = 32'sh0001_0000;
  localparam q16_t UN = 32'sh0000_0000;
  localparam q16_t BN = 32'sh0000_0000;
  localparam q16_t WO = 32'sh0001_0000;
  localparam q16_t BO = 32'sh0000_0000;

  localparam int X_LEN   = 8;
  localparam int X_IDX_W = $clog2(X_LEN);

  // NOTE: X_SEQ is a constant ROM, so it has no reset and no write port.
  localparam q16_t X_SEQ [X_LEN] = '{
    32'sh0001_0000, 32'sh0001_0000, 32'sh0001_0000, 32'sh0001_0000,
    32'sh0001_0000, 32'sh0001_0000, 32'sh0001_0000, 32'sh0001_0000
  };

  // Clip a wide signed value into the 32-bit Q16.16 range.
  function automatic q16_t q_sat(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) begin
      return Q_MAX;
    end else if (v < -64'sh0000_0000_8000_0000) begin
      return Q_MIN;
    end
    return v[31:0];
  endfunction

  // Full 64-bit product, rescaled by 2^16, then saturated.
  function automatic q16_t q_mul(input q16_t a, input q16_t b);
    logic signed [63:0] aw;
    logic signed [63:0] bw;
    aw = a;
    bw = b;
    return q_sat((aw * bw) >>> 16);
  endfunction

  function automatic q16_t q_add(input q16_t a, input q16_t b);
    logic signed [63:0] aw;
    logic signed [63:0] bw;
    aw = a;
    bw = b;
    return q_sat(aw + bw);
  endfunction

  function automatic q16_t q_sub(input q16_t a, input q16_t b);
    logic signed [63:0] aw;
    logic signed [63:0] bw;
    aw = a;
    bw = b;
    return q_sat(aw - bw);
  endfunction

  // Hard sigmoid: clamp(0.5 + v/4, 0, 1.0).
  function automatic q16_t q_sig(input q16_t v);
    q16_t s;
    s = q_add(Q_HALF, v >>> 2);
    if (s[31]) begin
      return '0;
    end else if (s > Q_ONE) begin
      return Q_ONE;
    end
    return s;
  endfunction

  // Hard tanh: clamp(v, -1.0, 1.0).
  function automatic q16_t q_tanh(input q16_t v);
    if (v > Q_ONE) begin
      return Q_ONE;
    end else if (v < Q_NEG_ONE) begin
      return Q_NEG_ONE;
    end
    return v;
  endfunction

endpackage

// File: rtl/gru_if.sv
// -----------------------------------------------------------------------------
// gru_if -- control/result link between gru_top and gru_model.
//
//   start   one-cycle request to run the sequence (ignored unless IDLE)
//   done    high while the model sits in DONE
//   result  final prediction, signed Q16.16, valid while done is high
//
// Modports: master (issues start), slave (the model).
// -----------------------------------------------------------------------------
interface gru_if;
  import gru_pkg::*;

  logic start;
  logic done;
  q16_t result;

  modport master (output start, input done, input result);
  modport slave  (input start, output done, output result);

endinterface

// File: rtl/gru_model.sv
// -----------------------------------------------------------------------------
// gru_model -- single-unit GRU datapath and sequencing FSM.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   gru_if.slave: start in, done/result out
//
// Each timestep walks LOAD -> GATES -> CAND -> UPDATE; after SEQ_LEN steps
// OUTPUT registers WO*h+BO and DONE holds it until reset.
// -----------------------------------------------------------------------------
module gru_model
  import gru_pkg::*;
#(
  parameter int SEQ_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  gru_if.slave bus
);

  localparam int CNT_W = $clog2(SEQ_LEN + 1);

  gru_state_t       state;
  logic [CNT_W-1:0] timestep_counter;

  q16_t x_t;
  q16_t h;
  q16_t z;
  q16_t r;
  q16_t n;
  q16_t result_q;
  logic done_q;

  q16_t z_next;
  q16_t r_next;
  q16_t n_next;
  q16_t h_next;
  q16_t y_next;

  // Each stage reads only registers written by earlier stages, so every
  // equation can be evaluated continuously and captured in its own state.
  assign z_next = q_sig(q_add(q_add(q_mul(WZ, x_t), q_mul(UZ, h)), BZ));
  assign r_next = q_sig(q_add(q_add(q_mul(WR, x_t), q_mul(UR, h)), BR));
  assign n_next = q_tanh(q_add(q_add(q_mul(WN, x_t), BN), q_mul(r, q_mul(UN, h))));
  assign h_next = q_add(q_mul(q_sub(Q_ONE, z), n), q_mul(z, h));
  assign y_next = q_add(q_mul(WO, h), BO);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      timestep_counter <= '0;
      x_t              <= '0;
      h                <= '0;
      z                <= '0;
      r                <= '0;
      n                <= '0;
      result_q         <= '0;
      done_q           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          x_t   <= X_SEQ[X_IDX_W'(timestep_counter)];
          state <= GATES;
        end
        GATES: begin
          z     <= z_next;
          r     <= r_next;
          state <= CAND;
        end
        CAND: begin
          n     <= n_next;
          state <= UPDATE;
        end
        UPDATE: begin
          h                <= h_next;
          timestep_counter <= timestep_counter + CNT_W'(1);
          // Decision uses the pre-increment count, so the counter ends at SEQ_LEN.
          if (int'(timestep_counter) < SEQ_LEN - 1) begin
            state <= LOAD;
          end else begin
            state <= OUTPUT;
          end
        end
        OUTPUT: begin
          result_q <= y_next;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: rtl/gru_top.sv
// -----------------------------------------------------------------------------
// gru_top -- board-level wrapper: start pulse generation, GRU model, UART TX.
//
// Ports:
//   CLOCK_50  system clock, rising edge
//   KEY       synchronous active-high reset (1 holds everything in reset)
//   UART_RXD  unused receive line
//   UART_TXD  8N1 transmit, idle high
//
// Internal nets of interest: model_done, final_prediction (signed Q16.16).
//
// Build option: define UART_TX_EN to include the transmitter, which sends
// final_prediction as 4 bytes MSB first once the model reaches DONE.
// Without it UART_TXD is tied high.
// -----------------------------------------------------------------------------
module gru_top
  import gru_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int SEQ_LEN  = 8
) (
  input  logic CLOCK_50,
  input  logic KEY,
  input  logic UART_RXD,
  output logic UART_TXD
);

  localparam logic [31:0] BIT_CYCLES = 32'(CLK_FREQ / BAUD);

  logic clk;
  logic rst;
  assign clk = CLOCK_50;
  assign rst = KEY;

  gru_if bus ();

  // 'armed' is set by reset and consumed by the first free-running edge,
  // giving exactly one start pulse per reset release.
  logic armed;
  logic start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b1;
      start_q <= 1'b0;
    end else begin
      start_q <= armed;
      armed   <= 1'b0;
    end
  end

  assign bus.start = start_q;

  gru_model #(
    .SEQ_LEN (SEQ_LEN)
  ) gru_inst (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic model_done;
  q16_t final_prediction;
  assign model_done       = bus.done;
  assign final_prediction = bus.result;

`ifdef UART_TX_EN
  localparam int BAUD_W = $clog2(BIT_CYCLES + 1);

  logic              done_q;
  logic              tx_busy;
  logic              txd_q;
  logic [39:0]       tx_shift;
  logic [5:0]        tx_bits_left;
  logic [BAUD_W-1:0] baud_cnt;
  logic [39:0]       frame;

  // Four 10-bit frames {stop, data, start}, shifted out LSB first; the most
  // significant byte occupies the lowest frame so it goes out first.
  assign frame = {1'b1, final_prediction[7:0],   1'b0,
                  1'b1, final_prediction[15:8],  1'b0,
                  1'b1, final_prediction[23:16], 1'b0,
                  1'b1, final_prediction[31:24], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q       <= 1'b0;
      tx_busy      <= 1'b0;
      txd_q        <= 1'b1;
      tx_shift     <= '0;
      tx_bits_left <= '0;
      baud_cnt     <= '0;
    end else begin
      done_q <= model_done;
      if (!tx_busy) begin
        if (model_done && !done_q) begin
          tx_busy      <= 1'b1;
          txd_q        <= frame[0];
          tx_shift     <= frame >> 1;
          tx_bits_left <= 6'd39;
          baud_cnt     <= BAUD_W'(BIT_CYCLES - 32'd1);
        end
      end else if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - BAUD_W'(1);
      end else if (tx_bits_left == '0) begin
        tx_busy <= 1'b0;
        txd_q   <= 1'b1;
      end else begin
        txd_q        <= tx_shift[0];
        tx_shift     <= tx_shift >> 1;
        tx_bits_left <= tx_bits_left - 6'd1;
        baud_cnt     <= BAUD_W'(BIT_CYCLES - 32'd1);
      end
    end
  end

  assign UART_TXD = txd_q;
`else
  assign UART_TXD = 1'b1;
`endif

  // Receive line and, in the transmitter-less build, the result nets have
  // no consumer inside this block.
  logic unused_ok;
  assign unused_ok = &{1'b0, UART_RXD, model_done, final_prediction, BIT_CYCLES[0]};

endmodule

// File: tb/tb_gru_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_gru_top -- self-checking bench for gru_top (and a standalone gru_model
// driven through gru_if for start-pulse handling).
// Expected values come from a real-number GRU model built from the package
// weights. UART_TX_EN selects the transmitter checks.
// -----------------------------------------------------------------------------
module tb_gru_top;
  import gru_pkg::*;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115_200;
  localparam int SEQ_LEN  = 8;
  localparam int BIT      = CLK_FREQ / BAUD;

  logic CLOCK_50 = 1'b0;
  logic KEY      = 1'b1;
  logic UART_RXD = 1'b1;
  logic UART_TXD;
  logic m_rst    = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  q16_t        exp_h [SEQ_LEN];
  q16_t        exp_final;
  logic [39:0] exp_bits;

  gru_top #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .SEQ_LEN  (SEQ_LEN)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .UART_RXD (UART_RXD),
    .UART_TXD (UART_TXD)
  );

  gru_if m_bus ();

  gru_model #(
    .SEQ_LEN (SEQ_LEN)
  ) u_model (
    .clk (CLOCK_50),
    .rst (m_rst),
    .bus (m_bus.slave)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real q2r(input q16_t v);
    return $itor(v) / 65536.0;
  endfunction

  function automatic q16_t r2q(input real v);
    return q16_t'($rtoi(v * 65536.0));
  endfunction

  function automatic real clampr(input real v, input real lo, input real hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic build_model();
    real hr, xr, zr, rr, nr;
    logic [7:0] b;
    hr = 0.0;
    for (int t = 0; t < SEQ_LEN; t++) begin
      xr = q2r(X_SEQ[t % X_LEN]);
      zr = clampr(0.5 + (q2r(WZ) * xr + q2r(UZ) * hr + q2r(BZ)) / 4.0, 0.0, 1.0);
      rr = clampr(0.5 + (q2r(WR) * xr + q2r(UR) * hr + q2r(BR)) / 4.0, 0.0, 1.0);
      nr = clampr(q2r(WN) * xr + q2r(BN) + rr * (q2r(UN) * hr), -1.0, 1.0);
      hr = (1.0 - zr) * nr + zr * hr;
      exp_h[t] = r2q(hr);
    end
    exp_final = r2q(q2r(WO) * hr + q2r(BO));
    // Serial line image: per byte (MSB byte first) start 0, data LSB first, stop 1.
    for (int i = 0; i < 4; i++) begin
      b = exp_final[31 - 8 * i -: 8];
      exp_bits[10 * i +: 10] = {1'b1, b, 1'b0};
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic hold_reset(input int cycles);
    KEY = 1'b1;
    repeat (cycles) begin
      @(posedge CLOCK_50); #1;
      UART_RXD = 1'($urandom);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(dut.gru_inst.state), 32'd0);
    check({tag, "_cnt"},   32'(dut.gru_inst.timestep_counter), 32'd0);
    check({tag, "_h"},     dut.gru_inst.h, 32'd0);
    check({tag, "_done"},  32'(dut.model_done), 32'd0);
    check({tag, "_final"}, dut.final_prediction, 32'd0);
    check({tag, "_txd"},   32'(UART_TXD), 32'd1);
  endtask

  // Releases reset and follows the run up to the edge where model_done rises.
  task automatic run_and_check(input string tag);
    int done_edge = 0;
    int updates   = 0;
    int prev_cnt  = 0;
    bit tx_low    = 1'b0;
    KEY = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge CLOCK_50); #1;
      UART_RXD = 1'($urandom);
      if (int'(dut.gru_inst.timestep_counter) != prev_cnt) begin
        if (prev_cnt < SEQ_LEN)
          check($sformatf("%s_h%0d", tag, prev_cnt), dut.gru_inst.h, exp_h[prev_cnt]);
        prev_cnt = int'(dut.gru_inst.timestep_counter);
        updates++;
      end
      if (UART_TXD !== 1'b1) tx_low = 1'b1;
      if (dut.model_done === 1'b1) begin
        done_edge = e;
        break;
      end
    end
    check({tag, "_done_edge"}, done_edge, 35);
    check({tag, "_updates"},   updates, SEQ_LEN);
    check({tag, "_final"},     dut.final_prediction, exp_final);
    check({tag, "_cnt_end"},   32'(dut.gru_inst.timestep_counter), SEQ_LEN);
    check({tag, "_state"},     32'(dut.gru_inst.state), 32'd6);
    check({tag, "_txd_idle"},  32'(tx_low), 32'd0);
  endtask

`ifdef UART_TX_EN
  // Called right after model_done rises; decodes the 40-bit serial stream.
  task automatic uart_decode(input string tag);
    bit          found    = 1'b0;
    bit          low      = 1'b1;
    bit          extra    = 1'b0;
    int          low_run  = 0;
    int          exp_low  = 0;
    logic [39:0] got_bits = '0;
    for (int k = 0; k < 40 && exp_bits[k] == 1'b0; k++) exp_low++;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (UART_TXD === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
    for (int c = 0; c < 40 * BIT; c++) begin
      if (c % BIT == BIT / 2) got_bits[c / BIT] = UART_TXD;
      if (low && UART_TXD === 1'b0) low_run++;
      else low = 1'b0;
      @(negedge CLOCK_50);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_frame%0d", tag, i), 32'(got_bits[10 * i +: 10]), 32'(exp_bits[10 * i +: 10]));
    check({tag, "_low_run"}, low_run, exp_low * BIT);
    for (int c = 0; c < 2 * BIT; c++) begin
      if (UART_TXD !== 1'b1) extra = 1'b1;
      @(negedge CLOCK_50);
    end
    check({tag, "_idle_after"}, 32'(extra), 32'd0);
    check({tag, "_done_sticky"}, 32'(dut.model_done), 32'd1);
    check({tag, "_final_held"},  dut.final_prediction, exp_final);
  endtask
`endif

  task automatic abort_in_cand3();
    bit found = 1'b0;
    KEY = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLOCK_50); #1;
      UART_RXD = 1'($urandom);
      if (dut.gru_inst.state == CAND && int'(dut.gru_inst.timestep_counter) == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("cand3_reached", 32'(found), 32'd1);
    KEY = 1'b1;
    @(posedge CLOCK_50); #1;
    check_reset_state("cand3_abort");
    hold_reset(3);
    run_and_check("cand3_rerun");
  endtask

  task automatic start_ignore_test();
    int done_e = 0;
    m_rst = 1'b1;
    m_bus.start = 1'b0;
    repeat (2) begin @(posedge CLOCK_50); #1; end
    check("m_reset_state", 32'(u_model.state), 32'd0);
    m_rst = 1'b0;
    @(posedge CLOCK_50); #1;
    check("m_wait_idle", 32'(u_model.state), 32'd0);
    m_bus.start = 1'b1;
    @(posedge CLOCK_50); #1;
    m_bus.start = 1'b0;
    check("m_load", 32'(u_model.state), 32'd1);
    for (int e = 1; e <= 50; e++) begin
      m_bus.start = 1'($urandom);
      @(posedge CLOCK_50); #1;
      if (m_bus.done === 1'b1) begin
        done_e = e;
        break;
      end
    end
    m_bus.start = 1'b1;
    @(posedge CLOCK_50); #1;
    m_bus.start = 1'b0;
    @(posedge CLOCK_50); #1;
    check("m_done_edge", done_e, 33);
    check("m_result", m_bus.result, exp_final);
    check("m_sticky_state", 32'(u_model.state), 32'd6);
    check("m_sticky_done", 32'(m_bus.done), 32'd1);
    m_rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    m_bus.start = 1'b0;
    build_model();

    check("sig_neg8",  q_sig(32'shFFF8_0000),  32'h0000_0000);
    check("sig_zero",  q_sig(32'sh0000_0000),  32'h0000_8000);
    check("sig_pos8",  q_sig(32'sh0008_0000),  32'h0001_0000);
    check("tanh_neg8", q_tanh(32'shFFF8_0000), 32'hFFFF_0000);
    check("tanh_zero", q_tanh(32'sh0000_0000), 32'h0000_0000);
    check("tanh_pos8", q_tanh(32'sh0008_0000), 32'h0001_0000);

    hold_reset(10);
    check_reset_state("reset");
    run_and_check("run1");
`ifdef UART_TX_EN
    uart_decode("uart1");
    hold_reset(2);
    check_reset_state("reset2");
    run_and_check("run2");
    repeat (1000) @(posedge CLOCK_50);
    #1;
    check("uart_mid_bit", 32'(UART_TXD), 32'(exp_bits[(1035 - 36) / BIT]));
    KEY = 1'b1;
    @(posedge CLOCK_50); #1;
    check("uart_abort_txd", 32'(UART_TXD), 32'd1);
    begin
      bit low = 1'b0;
      for (int c = 0; c < 2 * BIT; c++) begin
        @(posedge CLOCK_50); #1;
        if (UART_TXD !== 1'b1) low = 1'b1;
      end
      check("uart_abort_idle", 32'(low), 32'd0);
    end
`endif

    hold_reset(2);
    abort_in_cand3();

    k = $urandom_range(1, 40);
    KEY = 1'b0;
    repeat (k) begin
      @(posedge CLOCK_50); #1;
      UART_RXD = 1'($urandom);
    end
    KEY = 1'b1;
    @(posedge CLOCK_50); #1;
    check_reset_state("rnd_abort");
    hold_reset(4);
    run_and_check("rnd_rerun");

    start_ignore_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
